// File: rtl/uart_cmd_regs.sv
// uart_cmd_regs: framed UART command parser over a bank of read/write registers
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_data, rx_done    received byte and its one-cycle strobe
//   tx_data, tx_wr      byte to send and its one-cycle request
//   tx_done             previous byte has left the transmitter
//   regs_out            flat register bank, register i at [i*REG_WIDTH +: REG_WIDTH]
//   led                 low byte of register 0
//   err_count           saturating protocol error count
module uart_cmd_regs #(
    parameter int NUM_REGS       = 4,
    parameter int REG_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_done,
    output logic [7:0]                    tx_data,
    output logic                          tx_wr,
    input  logic                          tx_done,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_out,
    output logic [7:0]                    led,
    output logic [7:0]                    err_count
);
    localparam int BYTES = REG_WIDTH / 8;
    localparam int BW    = $clog2(BYTES + 1);
    localparam int GW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [REG_WIDTH-1:0] ACK_W = REG_WIDTH'(8'h06) << (REG_WIDTH - 8);
    localparam logic [REG_WIDTH-1:0] NAK_W = REG_WIDTH'(8'h15) << (REG_WIDTH - 8);

    typedef enum logic [1:0] {IDLE, DATA, RESP, TXWAIT} state_t;

    state_t               st, nxt;
    logic [6:0]           hdr_idx;
    logic [REG_WIDTH-1:0] asm_q, asm_nxt, tx_buf, src, rd_val;
    logic [BW-1:0]        byte_cnt, left, src_left;
    logic [GW-1:0]        gap_cnt;
    logic                 hdr_take, rx_valid, lat_valid, last, timeout, err_ev;

    assign led = regs_out[7:0];

    // Read snapshot is taken straight from the header byte, before it is latched.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rx_data[6:0] == 7'(i)) rd_val = regs_out[i*REG_WIDTH +: REG_WIDTH];
    end

    always_comb begin
        rx_valid  = int'(rx_data[6:0]) < NUM_REGS;
        lat_valid = int'(hdr_idx) < NUM_REGS;
        hdr_take  = st == IDLE && rx_done;
        last      = st == DATA && rx_done && byte_cnt == BW'(BYTES - 1);
        timeout   = st == DATA && !rx_done && gap_cnt == GW'(TIMEOUT_CYCLES);
        asm_nxt   = REG_WIDTH'({asm_q, rx_data});
        // Word the next transmitted byte is taken from: a fresh response or the remainder.
        src       = hdr_take ? (rx_valid ? rd_val : NAK_W) : last ? (lat_valid ? ACK_W : NAK_W) : tx_buf;
        src_left  = (hdr_take && rx_valid) ? BW'(BYTES) : (hdr_take || last) ? BW'(1) : left;
        err_ev    = (rx_done && (st == RESP || st == TXWAIT)) || timeout || (last && !lat_valid) ||
                    (hdr_take && !rx_data[7] && !rx_valid);
    end

    // RESP is the single cycle in which tx_wr is high.
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = rx_done ? (rx_data[7] ? DATA : RESP) : IDLE;
            DATA:    nxt = last ? RESP : timeout ? IDLE : DATA;
            RESP:    nxt = TXWAIT;
            TXWAIT:  nxt = tx_done ? (left != '0 ? RESP : IDLE) : TXWAIT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_idx   <= '0;
            asm_q     <= '0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            tx_wr     <= 1'b0;
            tx_data   <= 8'h00;
            tx_buf    <= '0;
            left      <= '0;
            regs_out  <= '0;
            err_count <= 8'h00;
        end else begin
            if (hdr_take) hdr_idx <= rx_data[6:0];
            byte_cnt <= hdr_take ? '0 : (st == DATA && rx_done) ? byte_cnt + 1'b1 : byte_cnt;
            gap_cnt  <= (st == DATA && !rx_done) ? gap_cnt + 1'b1 : '0;
            if (st == DATA && rx_done) asm_q <= asm_nxt;
            tx_wr <= nxt == RESP;
            if (nxt == RESP) begin
                tx_data <= src[REG_WIDTH-1 -: 8];
                tx_buf  <= REG_WIDTH'({src, 8'h00});
                left    <= src_left - 1'b1;
            end
            if (last && lat_valid)
                for (int i = 0; i < NUM_REGS; i++)
                    if (hdr_idx == 7'(i)) regs_out[i*REG_WIDTH +: REG_WIDTH] <= asm_nxt;
            if (err_ev && err_count != 8'hFF) err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_regs.sv
// tb_uart_cmd_regs: directed self-checking bench for uart_cmd_regs
module tb_uart_cmd_regs;
    logic        clk = 1'b0, rst = 1'b1, rx_done = 1'b0, tx_done = 1'b0, tx_wr;
    logic [7:0]  rx_data = 8'h00, tx_data, led, err_count;
    logic [63:0] regs_out;
    int          passed = 0, total = 0, seen = 0;

    uart_cmd_regs #(.NUM_REGS(4), .REG_WIDTH(16), .TIMEOUT_CYCLES(40)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_data(tx_data),
        .tx_wr(tx_wr), .tx_done(tx_done), .regs_out(regs_out), .led(led), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick;
        rx_done = 1'b0;
    endtask

    task automatic done;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    initial begin
        repeat (3) tick;
        rst = 1'b0;
        chk("rst_regs", regs_out, 64'h0);
        chk("rst_led", 64'(led), 64'h0);
        chk("rst_txwr", 64'(tx_wr), 64'h0);
        chk("rst_txdata", 64'(tx_data), 64'h0);
        chk("rst_err", 64'(err_count), 64'h0);
        // write reg0 = 0x1234
        send(8'h80); send(8'h12); send(8'h34);
        chk("wr0_ack_wr", 64'(tx_wr), 64'h1);
        chk("wr0_ack_data", 64'(tx_data), 64'h06);
        chk("wr0_regs", regs_out, 64'h0000_0000_0000_1234);
        chk("wr0_led", 64'(led), 64'h34);
        tick;
        chk("wr0_no_double", 64'(tx_wr), 64'h0);
        tick; done; tick;
        chk("wr0_idle", 64'(tx_wr), 64'h0);
        // read reg0
        send(8'h00);
        chk("rd0_b0_wr", 64'(tx_wr), 64'h1);
        chk("rd0_b0", 64'(tx_data), 64'h12);
        tick; tick;
        chk("rd0_b0_hold", 64'(tx_data), 64'h12);
        done;
        chk("rd0_b1_wr", 64'(tx_wr), 64'h1);
        chk("rd0_b1", 64'(tx_data), 64'h34);
        tick; done; tick;
        chk("rd0_end", 64'(tx_wr), 64'h0);
        // invalid write then invalid read
        send(8'h85); send(8'hAA); send(8'hBB);
        chk("wr5_nak_wr", 64'(tx_wr), 64'h1);
        chk("wr5_nak", 64'(tx_data), 64'h15);
        chk("wr5_err", 64'(err_count), 64'd1);
        chk("wr5_regs", regs_out, 64'h0000_0000_0000_1234);
        tick; done;
        send(8'h05);
        chk("rd5_nak", 64'(tx_data), 64'h15);
        chk("rd5_err", 64'(err_count), 64'd2);
        tick; done; tick;
        chk("rd5_single", 64'(tx_wr), 64'h0);
        // timeout mid-write
        send(8'h81); send(8'h55);
        for (int i = 0; i < 60; i++) begin
            tick;
            if (tx_wr) seen++;
        end
        chk("to_no_tx", 64'(seen), 64'd0);
        chk("to_err", 64'(err_count), 64'd3);
        chk("to_regs", regs_out, 64'h0000_0000_0000_1234);
        send(8'h81); send(8'hDE); send(8'hAD);
        chk("wr1_ack", 64'(tx_data), 64'h06);
        chk("wr1_regs", regs_out, 64'h0000_0000_DEAD_1234);
        tick; done;
        // byte arriving in the very cycle the gap reaches the limit is accepted
        send(8'h82);
        repeat (40) tick;
        send(8'hBE); send(8'hEF);
        chk("edge_ack_wr", 64'(tx_wr), 64'h1);
        chk("edge_ack", 64'(tx_data), 64'h06);
        chk("edge_regs", regs_out, 64'h0000_BEEF_DEAD_1234);
        chk("edge_err", 64'(err_count), 64'd3);
        tick; done;
        // rx byte during TXWAIT of a read response
        send(8'h01);
        chk("rd1_b0", 64'(tx_data), 64'hDE);
        tick;
        send(8'h77);
        chk("drop_err", 64'(err_count), 64'd4);
        chk("drop_no_tx", 64'(tx_wr), 64'h0);
        done;
        chk("rd1_b1_wr", 64'(tx_wr), 64'h1);
        chk("rd1_b1", 64'(tx_data), 64'hAD);
        tick; done; tick;
        chk("rd1_end", 64'(tx_wr), 64'h0);
        chk("drop_regs", regs_out, 64'h0000_BEEF_DEAD_1234);
        // saturate the error counter
        rx_data = 8'h7F;
        rx_done = 1'b1;
        repeat (301) tick;
        rx_done = 1'b0;
        chk("sat_err", 64'(err_count), 64'd255);
        chk("sat_nak", 64'(tx_data), 64'h15);
        done; tick;
        chk("sat_idle", 64'(tx_wr), 64'h0);
        // reset between data bytes
        send(8'h83); send(8'h11);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mrst_regs", regs_out, 64'h0);
        chk("mrst_led", 64'(led), 64'h0);
        chk("mrst_txwr", 64'(tx_wr), 64'h0);
        chk("mrst_txdata", 64'(tx_data), 64'h0);
        chk("mrst_err", 64'(err_count), 64'h0);
        done;
        chk("mrst_txdone_ign", 64'(tx_wr), 64'h0);
        send(8'h83); send(8'hCA); send(8'hFE);
        chk("wr3_ack_wr", 64'(tx_wr), 64'h1);
        chk("wr3_ack", 64'(tx_data), 64'h06);
        chk("wr3_regs", regs_out, 64'hCAFE_0000_0000_0000);
        chk("wr3_err", 64'(err_count), 64'h0);
        tick; done; tick;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_cmd_regs.md
# uart_cmd_regs

Byte-command register bank driven by the UART receive/transmit strobes of `uart_transceiver`. It parses a framed host protocol, writes or reads back `NUM_REGS` registers of `REG_WIDTH` bits each, and acknowledges every command over the transmit path. It also drives the board LEDs from register 0. It replaces the single-byte "rx byte → LED" path in the top level with an addressable, multi-byte, error-checked control plane.

## Interface
- `NUM_REGS`, default 4: number of registers; legal range 1..128.
- `REG_WIDTH`, default 16: register width; multiple of 8, range 8..32. `BYTES = REG_WIDTH/8`.
- `TIMEOUT_CYCLES`, default 500000: maximum `clk` cycles allowed between bytes of one write frame (10 ms at 50 MHz).
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte; valid only in the cycle `rx_done` is high.
- `rx_done` in 1: one-cycle strobe, one received byte.
- `tx_data` out 8: byte to transmit; held stable from the `tx_wr` cycle until `tx_done`.
- `tx_wr` out 1: one-cycle transmit request.
- `tx_done` in 1: one-cycle strobe, previous byte has fully left the transmitter.
- `regs_out` out `NUM_REGS*REG_WIDTH`: register contents; register i occupies bits `[i*REG_WIDTH +: REG_WIDTH]`.
- `led` out 8: `regs_out[7:0]` (register 0 low byte).
- `err_count` out 8: saturating count of protocol errors.

## Operation
- Header byte: bit 7 selects write (1) or read (0); bits 6:0 give the register index.
- Write frame: header, then `BYTES` data bytes, MSB first.
  - Valid index: the register updates atomically after the last byte, then ACK 0x06 is sent.
  - Index ≥ `NUM_REGS`: the data bytes are still consumed, then NAK 0x15 is sent, `err_count` +1, and no register changes.
- Read frame: header only.
  - Valid index: the register is snapshotted in the header cycle and the `BYTES` bytes are sent MSB first.
  - Invalid index: a single NAK 0x15 is sent and `err_count` +1.
- FSM states:
  - IDLE: `rx_done` → latch header. Write → DATA. Read → RESP.
  - DATA: shift `rx_data` into an assembly register and increment the byte counter on each `rx_done`. When the last byte arrives → RESP with ACK/NAK queued.
    - Gap counter clears on each `rx_done`. If it reaches `TIMEOUT_CYCLES` → IDLE, frame discarded, `err_count` +1, no response.
  - RESP: issue `tx_wr` with the next byte → TXWAIT.
  - TXWAIT: on `tx_done`, go to RESP if bytes remain, else IDLE.
- Any `rx_done` in RESP or TXWAIT: byte dropped, `err_count` +1. The parser is not resynchronised beyond returning to IDLE after the response completes.
- `err_count` saturates at 255 and never wraps. Multiple error events in one cycle count as 1.
- Reset values:
  - all registers 0, so `led` = 0
  - `tx_wr` 0, `tx_data` 0x00
  - `err_count` 0
  - FSM in IDLE, byte and gap counters 0
- Reset asserted mid-frame or mid-response aborts immediately. A byte already handed to the transmitter completes in the transceiver; its `tx_done` arrives while in IDLE and is ignored.

## Timing
- All outputs are registered.
- Write commit: `regs_out` and the ACK `tx_wr` change 1 cycle after the `rx_done` of the last data byte.
- Read: first `tx_wr` 1 cycle after the header `rx_done`. Each subsequent `tx_wr` 1 cycle after the preceding `tx_done`.
- `tx_wr` is never high in two consecutive cycles. At most one byte is outstanding.
- `tx_done` outside TXWAIT is ignored.
- Timeout: abort occurs in the cycle where the gap count equals `TIMEOUT_CYCLES`. An `rx_done` in that same cycle wins: the byte is accepted and no abort occurs.
- `rx_done` and `tx_done` in the same cycle are each handled per the current state. Both can matter only in TXWAIT, where the rx byte is dropped and counted.
- Gap counter width is `$clog2(TIMEOUT_CYCLES+1)`. The byte counter is sized for `BYTES`.

## Test plan
- Reset, then write reg 0 with bytes 0x80,0x12,0x34 (`REG_WIDTH`=16): reg0 = 0x1234, `led` = 0x34, ACK 0x06 with `tx_wr` 1 cycle after the last `rx_done`.
- After that write, read reg 0 with byte 0x00: tx sequence 0x12 then 0x34. Second `tx_wr` exactly 1 cycle after the first `tx_done`.
- Write to index 5 with `NUM_REGS`=4 (0x85,0xAA,0xBB): NAK 0x15, all registers unchanged, `err_count` = 1. Read 0x05 → single NAK, `err_count` = 2.
- Send 0x81, 0x55, then silence for `TIMEOUT_CYCLES`: no tx, `err_count` +1, reg1 unchanged. Then 0x81,0xDE,0xAD → reg1 = 0xDEAD, ACK.
- Inject an `rx_done` during TXWAIT of a read response: byte dropped, `err_count` +1, response bytes intact. Force 300 errors: `err_count` holds at 255.
- Assert `rst` between data bytes of a write: all outputs at reset values, no `tx_wr`. The next clean frame is parsed correctly.
